// File: rtl/bcd_counter_ndigit.sv
// Parametrised N-digit packed-BCD up/down counter with load, runtime terminal value,
// terminal flag F and wrap pulse. Define BCD_COUNTER_SAT_EN for saturating instead of wrapping.
module bcd_counter_ndigit #(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic [4*DIGITS-1:0] limit,
    output logic [4*DIGITS-1:0] count,
    output logic                F,
    output logic                wrap
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0] lim_s;
    logic [W-1:0] val_s;
    logic [W-1:0] count_inc;
    logic [W-1:0] count_dec;
    logic [W-1:0] count_next;
    logic         wrap_next;
    logic         f_next;

    // Clamp out-of-range digits to 9 so no non-BCD value can reach the count.
    function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic [3:0]   d;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            r[4*i +: 4] = (d > 4'd9) ? 4'd9 : d;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic [3:0]   d;
        logic         carry;
        r     = '0;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (carry) begin
                if (d == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = d + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                r[4*i +: 4] = d;
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic [3:0]   d;
        logic         borrow;
        r      = '0;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = d - 4'd1;
                    borrow      = 1'b0;
                end
            end else begin
                r[4*i +: 4] = d;
            end
        end
        return r;
    endfunction

    assign lim_s     = sanitize(limit);
    assign val_s     = sanitize(load_val);
    assign count_inc = bcd_inc(count);
    assign count_dec = bcd_dec(count);

    // Packed BCD with valid digits orders the same as plain unsigned binary.
    always_comb begin
        count_next = count;
        wrap_next  = 1'b0;
        if (load) begin
            count_next = val_s;
        end else if (start) begin
            if (up) begin
                if (count >= lim_s) begin
`ifdef BCD_COUNTER_SAT_EN
                    count_next = count;
`else
                    count_next = '0;
                    wrap_next  = 1'b1;
`endif
                end else begin
                    count_next = count_inc;
                end
            end else begin
                if (count == '0) begin
`ifdef BCD_COUNTER_SAT_EN
                    count_next = '0;
`else
                    count_next = lim_s;
                    wrap_next  = 1'b1;
`endif
                end else begin
                    count_next = count_dec;
                end
            end
        end
        f_next = (count_next == lim_s);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            F     <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            count <= count_next;
            F     <= f_next;
            wrap  <= wrap_next;
        end
    end

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Directed self-checking bench for bcd_counter_ndigit (2-, 4- and 1-digit instances).
module tb_bcd_counter_ndigit;

    logic clk = 1'b0;
    logic reset;

    logic       start2, up2, load2;
    logic [7:0] load_val2, limit2, count2;
    logic       f2, wrap2;

    logic        start4, up4, load4;
    logic [15:0] load_val4, limit4, count4;
    logic        f4, wrap4;

    logic       start1, up1, load1;
    logic [3:0] load_val1, limit1, count1;
    logic       f1, wrap1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_counter_ndigit #(.DIGITS(2)) u2 (
        .clk(clk), .reset(reset), .start(start2), .up(up2), .load(load2),
        .load_val(load_val2), .limit(limit2), .count(count2), .F(f2), .wrap(wrap2)
    );
    bcd_counter_ndigit #(.DIGITS(4)) u4 (
        .clk(clk), .reset(reset), .start(start4), .up(up4), .load(load4),
        .load_val(load_val4), .limit(limit4), .count(count4), .F(f4), .wrap(wrap4)
    );
    bcd_counter_ndigit #(.DIGITS(1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .up(up1), .load(load1),
        .load_val(load_val1), .limit(limit1), .count(count1), .F(f1), .wrap(wrap1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bcd2(input int i);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(i / 10);
        lo = 4'(i % 10);
        return {hi, lo};
    endfunction

    initial begin
        reset = 1'b1;
        start2 = 0; up2 = 1; load2 = 0; load_val2 = 8'h00; limit2 = 8'h59;
        start4 = 0; up4 = 1; load4 = 0; load_val4 = 16'h0000; limit4 = 16'h9999;
        start1 = 0; up1 = 1; load1 = 0; load_val1 = 4'h0; limit1 = 4'h0;
        tick();
        check("rst_count2", 16'(count2), 16'h00);
        check("rst_f2", 16'(f2), 16'h0);
        check("rst_wrap2", 16'(wrap2), 16'h0);
        check("rst_count4", count4, 16'h0000);
        check("rst_f1", 16'(f1), 16'h0);
        reset = 1'b0;

`ifndef BCD_COUNTER_SAT_EN
        // Full count 00..59 with L=59, then wrap to 00.
        start2 = 1; up2 = 1;
        for (int i = 1; i <= 59; i++) begin
            tick();
            check("up_count", 16'(count2), 16'(bcd2(i)));
            check("up_f", 16'(f2), 16'(i == 59));
            check("up_wrap", 16'(wrap2), 16'h0);
        end
        tick();
        check("wrap_count", 16'(count2), 16'h00);
        check("wrap_pulse", 16'(wrap2), 16'h1);
        check("wrap_f", 16'(f2), 16'h0);
        tick();
        check("after_wrap_count", 16'(count2), 16'h01);
        check("after_wrap_pulse", 16'(wrap2), 16'h0);

        // Down wrap and direction change, L=23.
        start2 = 0; limit2 = 8'h23; load2 = 1; load_val2 = 8'h01;
        tick();
        check("load01_count", 16'(count2), 16'h01);
        check("load01_wrap", 16'(wrap2), 16'h0);
        load2 = 0; start2 = 1; up2 = 0;
        tick();
        check("dn_count00", 16'(count2), 16'h00);
        check("dn_wrap0", 16'(wrap2), 16'h0);
        tick();
        check("dn_count23", 16'(count2), 16'h23);
        check("dn_wrap1", 16'(wrap2), 16'h1);
        check("dn_f23", 16'(f2), 16'h1);
        up2 = 1;
        tick();
        check("dirchg_count", 16'(count2), 16'h00);
        check("dirchg_wrap", 16'(wrap2), 16'h1);
        check("dirchg_f", 16'(f2), 16'h0);

        // Load beats start; reset beats load.
        limit2 = 8'h59; load2 = 1; load_val2 = 8'h37; start2 = 1; up2 = 1;
        tick();
        check("prio_load", 16'(count2), 16'h37);
        load2 = 0;
        tick();
        check("run38", 16'(count2), 16'h38);
        tick();
        tick();
        check("carry40", 16'(count2), 16'h40);
        reset = 1; load2 = 1;
        tick();
        check("midrst_count", 16'(count2), 16'h00);
        check("midrst_f", 16'(f2), 16'h0);
        check("midrst_wrap", 16'(wrap2), 16'h0);
        reset = 0; load2 = 0; start2 = 0;

        // Sanitising: load A5 -> 95, limit 3F -> 39.
        limit2 = 8'h3F; load_val2 = 8'hA5; load2 = 1;
        tick();
        check("san_count95", 16'(count2), 16'h95);
        check("san_f", 16'(f2), 16'h0);
        load2 = 0; start2 = 1; up2 = 1;
        tick();
        check("over_count", 16'(count2), 16'h00);
        check("over_wrap", 16'(wrap2), 16'h1);
        load2 = 1; load_val2 = 8'h38;
        tick();
        check("ld38_count", 16'(count2), 16'h38);
        check("ld38_wrap", 16'(wrap2), 16'h0);
        load2 = 0;
        tick();
        check("san_count39", 16'(count2), 16'h39);
        check("san_f39", 16'(f2), 16'h1);
        tick();
        check("san_wrap_count", 16'(count2), 16'h00);
        check("san_wrap_pulse", 16'(wrap2), 16'h1);
        check("san_wrap_f", 16'(f2), 16'h0);
        // Limit change alone shows on F one cycle later.
        start2 = 0; limit2 = 8'h00;
        tick();
        check("lim_f", 16'(f2), 16'h1);
        check("lim_hold", 16'(count2), 16'h00);
        check("lim_hold_wrap", 16'(wrap2), 16'h0);

        // Four digits: full ripple carry and full borrow.
        load4 = 1; load_val4 = 16'h0999;
        tick();
        check("d4_load", count4, 16'h0999);
        load4 = 0; start4 = 1; up4 = 1;
        tick();
        check("d4_ripple", count4, 16'h1000);
        check("d4_wrap", 16'(wrap4), 16'h0);
        up4 = 0;
        tick();
        check("d4_borrow", count4, 16'h0999);
        start4 = 0;

        // One digit, L=0: every up step wraps and F stays 1.
        start1 = 1; up1 = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("d1_count", 16'(count1), 16'h0);
            check("d1_wrap", 16'(wrap1), 16'h1);
            check("d1_f", 16'(f1), 16'h1);
        end
        start1 = 0;
        tick();
        check("d1_stop_wrap", 16'(wrap1), 16'h0);
`else
        // Saturating build: L=12 counting up from 10.
        limit2 = 8'h12; load_val2 = 8'h10; load2 = 1;
        tick();
        check("sat_load", 16'(count2), 16'h10);
        load2 = 0; start2 = 1; up2 = 1;
        tick();
        check("sat_11", 16'(count2), 16'h11);
        check("sat_w11", 16'(wrap2), 16'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("sat_12", 16'(count2), 16'h12);
            check("sat_w12", 16'(wrap2), 16'h0);
            check("sat_f12", 16'(f2), 16'h1);
        end
        load2 = 1; load_val2 = 8'h00;
        tick();
        check("sat_ld00", 16'(count2), 16'h00);
        load2 = 0; up2 = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("sat_dn00", 16'(count2), 16'h00);
            check("sat_dnw", 16'(wrap2), 16'h0);
        end
        start1 = 1; up1 = 1;
        tick();
        check("sat_d1_count", 16'(count1), 16'h0);
        check("sat_d1_wrap", 16'(wrap1), 16'h0);
        check("sat_d1_f", 16'(f1), 16'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_counter_ndigit.md
# bcd_counter_ndigit

Parametrised multi-digit BCD up/down counter with run enable, parallel load, a runtime terminal value, a terminal-count flag and a wrap pulse. It is the general-purpose replacement for fixed two-digit counters in our display and timing paths: one instance drives N packed BCD digits straight into seven-segment decoders and flags the terminal count to surrounding control FSMs.

## Interface
- `DIGITS`, default 2: number of BCD digits, legal range 1..8; the counter is 4*DIGITS bits wide.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: count enable; the counter steps once per cycle while high.
- `up` in 1: direction; 1 counts up, 0 counts down. Sampled only when stepping.
- `load` in 1: parallel load strobe.
- `load_val` in 4*DIGITS: packed BCD load value; digit 0 is in [3:0].
- `limit` in 4*DIGITS: packed BCD terminal value. Held static by the user except between runs.
- `count` out 4*DIGITS: packed BCD count; digit 0 is in [3:0].
- `F` out 1: terminal flag, high while `count` equals the sanitised `limit`.
- `wrap` out 1: one-cycle pulse on a wrap-around step.

## Operation
- Sanitising: any `load_val` or `limit` digit greater than 9 is treated as 9.
  - Let L be the sanitised `limit` and V the sanitised `load_val`.
- Priority per cycle: `reset` > `load` > `start`. With none of them asserted, everything holds and `wrap` is 0.
- `reset`: `count`=0, `F`=0, `wrap`=0.
- `load`: `count` takes V, `wrap`=0, and `start` is ignored that cycle.
  - V greater than L is legal.
- Up step (`start`=1, `up`=1):
  - If `count` >= L, then `count` becomes 0 and `wrap`=1.
  - Otherwise `count` increments by one in BCD. A digit at 9 becomes 0 and carries into the next digit, rippling through all digits in the same cycle.
- Down step (`start`=1, `up`=0):
  - If `count`==0, then `count` becomes L and `wrap`=1.
  - Otherwise `count` decrements by one in BCD. A digit at 0 becomes 9 and borrows from the next digit.
- `F` is registered as (next `count` == L).
  - A change on `limit` alone is reflected on `F` one cycle later.
- L=0: an up step from 0 wraps to 0 with `wrap`=1, and `F` stays 1.
- Every `count` digit is always in the range 0..9; no non-BCD value ever appears.

## Timing
- Single-cycle latency: the inputs sampled at edge k determine `count`, `F` and `wrap` after edge k.
- All outputs are registered, with no combinational input-to-output path.
- `wrap` is high for exactly one cycle per wrap event. It stays high on consecutive cycles only when consecutive steps each wrap (e.g. L=0 counting up).
- `reset` asserted mid-count clears all outputs at the next edge, regardless of `load` and `start`.
- Direction may change on any cycle. The step taken follows `up` as sampled at that edge.
- Reset values: `count`=0, `F`=0, `wrap`=0.

## Configuration
- `BCD_COUNTER_SAT_EN` defined: saturating mode.
  - An up step at `count` >= L leaves `count` unchanged.
  - A down step at 0 leaves `count` at 0.
  - `wrap` is tied to 0.
  - All other behaviour, including load, `F` and priority, is unchanged.
- `BCD_COUNTER_SAT_EN` not defined: wrapping behaviour as described in Operation.
- The port list is identical in both builds.

## Test plan
All scenarios use DIGITS=2, no macro, unless stated otherwise.
- Reset and full count: reset, L=59, `start`=1, `up`=1 for 60 cycles.
  - `count` runs 00..59 with digit carries at 09→10 and 49→50.
  - `F`=1 only at 59; the next step gives 00 with a single `wrap` pulse.
- Down wrap and direction change: L=23, load 01, then step down twice.
  - Sequence 01→00→23 with `wrap`=1 on the second step.
  - Set `up`=1 and step once: `count`=00.
- Priority and reset mid-run: with `start`=1 and `load`=1 (V=37), `count`=37.
  - At `count`=40, assert `reset` together with `load`: all outputs 0 next cycle.
- Sanitising and over-limit load: load 0xA5 with L=0x3F.
  - `count`=95 and L is taken as 39.
  - The next up step gives 00 with `wrap`=1; `F` tracks 39.
- Edge widths: DIGITS=4, L=9999, load 0999 and step up once: `count`=1000 with a full ripple carry.
  - DIGITS=1, L=0: every up step gives `wrap`=1 and `F` stays 1.
- Saturating build (`BCD_COUNTER_SAT_EN` defined), L=12, counting up from 10 for 5 cycles.
  - `count` goes 11, 12, 12, 12, 12 with `wrap` always 0.
  - Counting down from 00 stays at 00.
